// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: owns the PC, sequences advance/stall/redirect/halt,
// and registers the fetched word into IF/ID. Bad fetch addresses park it in FAULT.
module fetch_sequencer #(
  parameter int unsigned RESET_PC  = 100,
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] fetch_count,
  output logic        fetch_fault,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [31:0] LAST_PC  = 32'(MEM_BYTES - 4);
  localparam logic [31:0] RESET_AD = 32'(RESET_PC);

  // Handshake: redirect_valid qualifies redirect_pc for the current cycle only;
  // there is no ready, a redirect is consumed on the edge where it is seen.

  state_t      state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic        valid_q, valid_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] pp4_q, pp4_n;
  logic [31:0] count_q, count_n;
  logic        fault_q, fault_n;
  logic        target_legal;

  assign target_legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_PC);

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    valid_n = valid_q;
    instr_n = instr_q;
    pp4_n   = pp4_q;
    count_n = count_q;
    fault_n = fault_q;
    case (state_q)
      IDLE: state_n = RUN;
      RUN: begin
        if (redirect_valid) begin
          valid_n = 1'b0;
          instr_n = '0;
          pp4_n   = '0;
          if (target_legal) begin
            pc_n = redirect_pc;
          end else begin
            state_n = FAULT;
            fault_n = 1'b1;
          end
        end else if (halt_req) begin
          state_n = HALTED;
          valid_n = 1'b0;
          instr_n = '0;
          pp4_n   = '0;
        end else if (!stall) begin
          valid_n = 1'b1;
          instr_n = imem_instr;
          pp4_n   = pc_q + 32'd4;
          count_n = count_q + 32'd1;
          // The last word is still delivered; the PC parks instead of leaving memory.
          if (pc_q == LAST_PC) begin
            state_n = FAULT;
            fault_n = 1'b1;
          end else begin
            pc_n = pc_q + 32'd4;
          end
        end
      end
      HALTED: begin
        valid_n = 1'b0;
        instr_n = '0;
        pp4_n   = '0;
        if (redirect_valid) begin
          if (target_legal) begin
            pc_n    = redirect_pc;
            state_n = RUN;
          end else begin
            state_n = FAULT;
            fault_n = 1'b1;
          end
        end
      end
      FAULT: begin
        valid_n = 1'b0;
        instr_n = '0;
        pp4_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_AD;
      valid_q <= 1'b0;
      instr_q <= '0;
      pp4_q   <= '0;
      count_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      valid_q <= valid_n;
      instr_q <= instr_n;
      pp4_q   <= pp4_n;
      count_q <= count_n;
      fault_q <= fault_n;
    end
  end

  assign imem_pc       = pc_q;
  assign ifid_valid    = valid_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus4 = pp4_q;
  assign fetch_count   = count_q;
  assign fetch_fault   = fault_q;
  assign state         = state_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front-end controller for the byte-addressed, big-endian, combinational-read instruction memory.
- Generates the fetch PC every cycle and owns PC sequencing: advance by 4, stall, redirect on branch/jump/jr, halt.
- Registers the returned word into the IF/ID stage with valid, PC+4 and a delivered-instruction count.
- Detects misaligned or out-of-range fetch addresses and parks in a sticky fault state.

Parameters:
- RESET_PC, 100, first fetch address after reset; must be word-aligned.
- MEM_BYTES, 16384, instruction memory size in bytes; the highest legal fetch PC is MEM_BYTES-4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit request to hold the PC and IF/ID.
- redirect_valid  in  1  branch/jump/jr target valid this cycle.
- redirect_pc  in  32  redirect target address.
- halt_req  in  1  request to stop fetching.
- imem_pc  out  32  address to instruction memory; equals the internal PC register.
- imem_instr  in  32  instruction word at imem_pc, same cycle.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc_plus4  out  32  fetch PC of the IF/ID instruction, plus 4.
- fetch_count  out  32  number of instructions delivered into IF/ID.
- fetch_fault  out  1  sticky fault flag.
- state  out  2  IDLE=0, RUN=1, HALTED=2, FAULT=3.

Behaviour:
- Reset, evaluated at a clk edge: state=IDLE, pc=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc_plus4=0, fetch_count=0, fetch_fault=0. Reset overrides every other input, including mid-operation and in FAULT.
- IDLE: lasts exactly one cycle with no fetch, then goes to RUN. Inputs are ignored in IDLE.
- RUN priority per cycle: redirect > halt_req > stall > advance.
  - Redirect, legal target: pc<=redirect_pc; IF/ID flushed (valid=0, instr=0, pc_plus4=0); fetch_count unchanged. A redirect in the same cycle as stall still wins.
  - halt_req: state<=HALTED; IF/ID flushed; pc holds.
  - stall: pc and all IF/ID fields hold.
  - Advance: ifid_instr<=imem_instr; ifid_pc_plus4<=pc+4; ifid_valid<=1; fetch_count+=1; pc<=pc+4.
- Fetch latency: the instruction at pc appears on the ifid_* outputs one cycle after pc is presented.
- HALTED:
  - pc holds; ifid_valid=0.
  - stall and halt_req are ignored.
  - redirect_valid with a legal target: pc<=redirect_pc, state<=RUN, and the first fetch is on the next cycle.
- Legal target: redirect_pc[1:0]==0 and redirect_pc<=MEM_BYTES-4.
- Illegal redirect, in RUN or HALTED: state<=FAULT, fetch_fault<=1, IF/ID flushed, pc keeps its previous value.
- End of memory: an advance at pc==MEM_BYTES-4 still latches that instruction. The same edge moves to FAULT: fetch_fault<=1, pc holds at MEM_BYTES-4. Outputs on the following cycle: ifid_valid=1 with that last instruction, ifid_pc_plus4=MEM_BYTES. One cycle later ifid_valid=0.
- FAULT: sticky; only reset exits. pc holds, ifid_valid=0 after the residual cycle above, and all inputs are ignored.
- Arithmetic: all 32-bit unsigned. fetch_count wraps modulo 2^32. pc+4 never wraps because of the range check.
- imem_pc is a pure function of the pc register and is never combinationally driven from inputs.

Test Plan:
- Sequential fetch.
  - Stimulus: reset 1 cycle, then no other inputs; memory holds 0x48080000@100, 0x48090004@104, 0x480a0008@108.
  - Required: cycle after reset has state=IDLE, imem_pc=100. Then on consecutive cycles ifid_instr=0x48080000/0x48090004/0x480a0008 with ifid_pc_plus4=104/108/112, and fetch_count=3.
- Stall with redirect.
  - Stimulus: in RUN at pc=208, assert stall=1 for 2 cycles, then stall=1 together with redirect_valid=1, redirect_pc=296.
  - Required: pc holds 208 and IF/ID holds during the stall. On the redirect edge pc=296 and ifid_valid=0. Next cycle ifid_instr=0x0c100008, ifid_pc_plus4=300.
- Halt then resume.
  - Stimulus: halt_req at pc=220; then stall toggles for 5 cycles; then redirect_pc=300.
  - Required: state=HALTED, ifid_valid=0 and pc=220 throughout the stall toggling. After the redirect, state=RUN and the next IF/ID holds the word at 300 with ifid_pc_plus4=304.
- Misaligned redirect.
  - Stimulus: redirect_pc=202 at pc=104.
  - Required: state=FAULT, fetch_fault=1, pc=104. Later redirects and halt_req are ignored. A subsequent reset returns pc=100, fetch_fault=0.
- Out-of-range redirect.
  - Stimulus: redirect_pc=16384.
  - Required: FAULT, pc unchanged.
- End of memory.
  - Stimulus: redirect_pc=16376, then free-run.
  - Required: the words at 16376 and 16380 are delivered with ifid_pc_plus4=16380 then 16384. After that, state=FAULT, pc=16380, and ifid_valid=0 one cycle later.
